// File: rtl/vram_sched.sv
// ---------------------------------------------------------------------------
// vram_sched
//
// Frame-sequenced DDR command scheduler (memory-interface clock domain).
// Each frame trigger starts one linear pass over the waveform-state buffer.
// The pass interleaves burst reads, which refill the VRAM-to-EPDC FIFO, with
// burst write-backs, which drain the EPDC-to-VRAM FIFO. All bursts go through
// the memory interface's single command port.
//
// Reads are never overtaken by writes. Reads may lead writes by at most
// LEAD_BURSTS bursts.
//
// Optional build macro: VRAM_SCHED_STATS_EN
//   When it is defined, a saturating counter is built. It counts the cycles in
//   which the arbiter had nothing eligible. Its value is published on
//   stall_cycles at the end of each frame.
//   When it is undefined, stall_cycles is tied to zero.
//
// Parameters
//   MAX_ADDRESS  frame buffer size in bytes (multiple of BURST_WORDS*16)
//   ADDR_W       byte address width
//   BURST_WORDS  128-bit words per command
//   LEAD_BURSTS  maximum read lead over writes, in bursts
//
// Ports
//   clk             memory-interface clock
//   rst             asynchronous active-high reset
//   vsync           frame trigger (already synchronous); rising edge starts a frame
//   ddr_calib_done  DDR calibration complete
//   rd_room         read FIFO can take one full burst
//   wr_avail        write FIFO holds at least one full burst
//   cmd_valid       command presented
//   cmd_ready       memory interface accepts the command
//   cmd_write       1 = write burst, 0 = read burst
//   cmd_addr        burst start byte address
//   cmd_bl          burst length minus one (constant)
//   frame_busy      frame pass in progress
//   frame_done      one-cycle pulse when both streams have reached MAX_ADDRESS
//   overrun         sticky: a frame trigger arrived while busy
//   stall_cycles    arbiter stall count of the last completed frame
// ---------------------------------------------------------------------------
module vram_sched #(
   parameter int MAX_ADDRESS = 3840000,
   parameter int ADDR_W      = 30,
   parameter int BURST_WORDS = 4,
   parameter int LEAD_BURSTS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              ddr_calib_done,
   input  logic              rd_room,
   input  logic              wr_avail,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [5:0]        cmd_bl,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              overrun,
   output logic [15:0]       stall_cycles
);

   // Scheduler states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARB   = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Byte-domain constants, sized to the address counters
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_WORDS * 16);
   localparam logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(MAX_ADDRESS);
   localparam logic [ADDR_W-1:0] LEAD_BYTES  = ADDR_W'(LEAD_BURSTS * BURST_WORDS * 16);

   logic [1:0]        state;
   logic              vsync_q;
   logic              vsync_edge;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_next;
   logic [ADDR_W-1:0] wr_next;
   logic              last_write;
   logic              rd_elig;
   logic              wr_elig;
   logic              any_elig;
   logic              grant_write;
   logic              issue_hs;
   logic              last_hs;
   logic              frame_start;

   // The burst length never changes, so it is a constant, not a register
   assign cmd_bl = 6'(BURST_WORDS - 1);

   // Single-register edge detector on the already-synchronised frame trigger
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q <= 1'b0;
      end else begin
         vsync_q <= vsync;
      end
   end

   assign vsync_edge = vsync & ~vsync_q;

   // Eligibility. The invariant rd_addr >= wr_addr holds, so the lead
   // subtraction never wraps. A write is allowed only behind the read pointer,
   // so it never touches data that has not been read yet.
   assign rd_elig  = rd_room && (rd_addr < MAX_ADDR) && ((rd_addr - wr_addr) < LEAD_BYTES);
   assign wr_elig  = wr_avail && (wr_addr < rd_addr);
   assign any_elig = rd_elig | wr_elig;

   // Round-robin between the streams. A write wins only if reads are not
   // eligible, or if the previous grant went to a read.
   assign grant_write = wr_elig && (!rd_elig || !last_write);

   // Counter values after the handshake of the presented command
   assign rd_next = cmd_write ? rd_addr : (rd_addr + BURST_BYTES);
   assign wr_next = cmd_write ? (wr_addr + BURST_BYTES) : wr_addr;

   // A real handshake needs a healthy interface and no restart in the same
   // cycle; calibration loss and overrun restarts both pre-empt acceptance.
   assign issue_hs = (state == ST_ISSUE) && ddr_calib_done && !vsync_edge && cmd_ready;
   assign last_hs  = issue_hs && (rd_next == MAX_ADDR) && (wr_next == MAX_ADDR);

   // A counter clear happens in two cases: a normal start from IDLE, and an
   // overrun restart from ARB or ISSUE. No restart happens while DONE lasts.
   assign frame_start = vsync_edge && ddr_calib_done && (state != ST_DONE);

   // Main sequencer. It owns the stream counters, the round-robin bit and every
   // registered command/status output. frame_busy and frame_done are written
   // from the next state, so they line up exactly with ARB/ISSUE and DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         rd_addr    <= '0;
         wr_addr    <= '0;
         last_write <= 1'b1;
         cmd_valid  <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (vsync_edge && ddr_calib_done) begin
                  rd_addr    <= '0;
                  wr_addr    <= '0;
                  state      <= ST_ARB;
                  frame_busy <= 1'b1;
               end
            end

            ST_ARB: begin
               if (!ddr_calib_done) begin
                  state      <= ST_IDLE;
                  frame_busy <= 1'b0;
               end else if (vsync_edge) begin
                  overrun <= 1'b1;
                  rd_addr <= '0;
                  wr_addr <= '0;
               end else if (any_elig) begin
                  cmd_valid <= 1'b1;
                  cmd_write <= grant_write;
                  cmd_addr  <= grant_write ? wr_addr : rd_addr;
                  state     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               // Without calibration the interface cannot accept the command.
               // It is dropped here, and the counters are left untouched.
               if (!ddr_calib_done) begin
                  cmd_valid  <= 1'b0;
                  state      <= ST_IDLE;
                  frame_busy <= 1'b0;
               end else if (vsync_edge) begin
                  // The trigger also resets the FIFOs. The pending command is
                  // stale, so it is withdrawn.
                  overrun   <= 1'b1;
                  rd_addr   <= '0;
                  wr_addr   <= '0;
                  cmd_valid <= 1'b0;
                  state     <= ST_ARB;
               end else if (cmd_ready) begin
                  cmd_valid  <= 1'b0;
                  rd_addr    <= rd_next;
                  wr_addr    <= wr_next;
                  last_write <= cmd_write;
                  if (last_hs) begin
                     state      <= ST_DONE;
                     frame_done <= 1'b1;
                     frame_busy <= 1'b0;
                  end else begin
                     state <= ST_ARB;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state      <= ST_IDLE;
               cmd_valid  <= 1'b0;
               frame_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef VRAM_SCHED_STATS_EN
   logic [15:0] stall_cnt;

   // Stall statistics. This block counts the ARB cycles in which neither stream
   // could go, saturating at all-ones. The count restarts with every frame
   // start or restart. It is copied to the output on the same edge that raises
   // frame_done, so the published value belongs to the frame just completed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         stall_cycles <= '0;
      end else begin
         if (frame_start) begin
            stall_cnt <= '0;
         end else if ((state == ST_ARB) && ddr_calib_done && !any_elig &&
                      (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (last_hs) begin
            stall_cycles <= stall_cnt;
         end
      end
   end
`else
   // Statistics not built
   assign stall_cycles = '0;

   // The restart qualifier only feeds the statistics counter
   logic unused_stats;
   assign unused_stats = frame_start;
`endif

endmodule

// File: tb/tb_vram_sched.sv
// ---------------------------------------------------------------------------
// tb_vram_sched
//
// Directed bench for vram_sched. The DUT is built with MAX_ADDRESS = 512, so a
// frame holds eight read bursts and eight write bursts. With the 4-burst lead
// limit, the read lead bound and the end-of-buffer bound are distinct. All
// expected command streams below are worked out by hand for this size.
// Inputs change on the falling edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_vram_sched;

   localparam int MaxAddress = 512;

`ifdef VRAM_SCHED_STATS_EN
   localparam int ExpStall = 20;
`else
   localparam int ExpStall = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        calibDone;
   logic        rdRoom;
   logic        wrAvail;
   logic        cmdValid;
   logic        cmdReady;
   logic        cmdWrite;
   logic [29:0] cmdAddr;
   logic [5:0]  cmdBl;
   logic        frameBusy;
   logic        frameDone;
   logic        overrun;
   logic [15:0] stallCycles;

   int vectorCount = 0;
   int missCount   = 0;

   // Lead-limited stream: expected commands after wr_avail is released, with
   // four reads already issued (rd=256, wr=0)
   int leadWrite [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
   int leadAddr  [12] = '{0, 256, 64, 320, 128, 384, 192, 448, 256, 320, 384, 448};

   vram_sched #(
      .MAX_ADDRESS (MaxAddress),
      .ADDR_W      (30),
      .BURST_WORDS (4),
      .LEAD_BURSTS (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .vsync          (vsync),
      .ddr_calib_done (calibDone),
      .rd_room        (rdRoom),
      .wr_avail       (wrAvail),
      .cmd_valid      (cmdValid),
      .cmd_ready      (cmdReady),
      .cmd_write      (cmdWrite),
      .cmd_addr       (cmdAddr),
      .cmd_bl         (cmdBl),
      .frame_busy     (frameBusy),
      .frame_done     (frameDone),
      .overrun        (overrun),
      .stall_cycles   (stallCycles)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case something below misbehaves despite the bounded waits
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got still running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the vector, reports a miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the flow-control inputs
   task automatic applyStimulus(input logic room, input logic avail, input logic ready);
      rdRoom   = room;
      wrAvail  = avail;
      cmdReady = ready;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One-cycle trigger pulse; returns on the falling edge after the sampling edge
   task automatic pulseVsync();
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
   endtask

   // Wait for a command that is accepted on the next rising edge. Returns on
   // the falling edge after that handshake.
   task automatic waitCmd(input int budget, output logic isWrite,
                          output logic [29:0] addr, output logic timedOut);
      int  n;
      logic seen;
      n = 0;
      seen = 1'b0;
      isWrite = 1'b0;
      addr = '0;
      while (!seen && n < budget) begin
         if (cmdValid && cmdReady) begin
            isWrite = cmdWrite;
            addr = cmdAddr;
            seen = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      timedOut = !seen;
   endtask

   task automatic expectCmd(input string tag, input int expWrite, input int expAddr);
      logic        w;
      logic [29:0] a;
      logic        to;
      waitCmd(40, w, a, to);
      checkOutput({tag, " timeout"}, 32'(to), 32'd0);
      checkOutput({tag, " write"}, 32'(w), 32'(expWrite));
      checkOutput({tag, " addr"}, 32'(a), 32'(expAddr));
   endtask

   // Fully open flow control alternates R,W at the same address
   task automatic checkSeq(input string tag, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         expectCmd($sformatf("%s cmd%0d", tag, i), i % 2, (i / 2) * 64);
      end
   endtask

   // Called on the falling edge right after the final handshake
   task automatic checkFrameEnd(input string tag);
      checkOutput({tag, " frame_done high"}, 32'(frameDone), 32'd1);
      checkOutput({tag, " busy low"}, 32'(frameBusy), 32'd0);
      @(negedge clk);
      checkOutput({tag, " frame_done one cycle"}, 32'(frameDone), 32'd0);
   endtask

   initial begin
      int   badCount;
      logic sawValid;
      rst = 1'b1;
      vsync = 1'b0;
      calibDone = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // ---- reset values ----
      applyReset();
      checkOutput("rst cmd_valid", 32'(cmdValid), 32'd0);
      checkOutput("rst cmd_write", 32'(cmdWrite), 32'd0);
      checkOutput("rst cmd_addr", 32'(cmdAddr), 32'd0);
      checkOutput("rst cmd_bl", 32'(cmdBl), 32'd3);
      checkOutput("rst frame_busy", 32'(frameBusy), 32'd0);
      checkOutput("rst frame_done", 32'(frameDone), 32'd0);
      checkOutput("rst overrun", 32'(overrun), 32'd0);
      checkOutput("rst stall_cycles", 32'(stallCycles), 32'd0);

      // ---- trigger ignored while calibration is low ----
      calibDone = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1);
      pulseVsync();
      sawValid = 1'b0;
      badCount = 0;
      for (int i = 0; i < 6; i++) begin
         if (cmdValid) sawValid = 1'b1;
         if (frameBusy) badCount++;
         if (i == 2) calibDone = 1'b1;
         @(negedge clk);
      end
      checkOutput("nocal no command", 32'(sawValid), 32'd0);
      checkOutput("nocal busy cycles", 32'(badCount), 32'd0);

      // ---- open flow: full alternating frame ----
      applyReset();
      applyStimulus(1'b1, 1'b1, 1'b1);
      pulseVsync();
      checkOutput("open busy at N+1", 32'(frameBusy), 32'd1);
      checkOutput("open no valid at N+1", 32'(cmdValid), 32'd0);
      @(negedge clk);
      checkOutput("open valid at N+2", 32'(cmdValid), 32'd1);
      checkOutput("open first bl", 32'(cmdBl), 32'd3);
      checkSeq("open", 0, 16);
      checkFrameEnd("open");
      checkOutput("open overrun", 32'(overrun), 32'd0);

      // ---- writes held off: read lead limit, then writes resume ----
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b1);
      pulseVsync();
      for (int i = 0; i < 4; i++) begin
         expectCmd($sformatf("lead read%0d", i), 0, i * 64);
      end
      sawValid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (cmdValid) sawValid = 1'b1;
         @(negedge clk);
      end
      checkOutput("lead stops at 4", 32'(sawValid), 32'd0);
      checkOutput("lead still busy", 32'(frameBusy), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         expectCmd($sformatf("lead resume%0d", i), leadWrite[i], leadAddr[i]);
      end
      checkFrameEnd("lead");

      // ---- back-pressure: first command held for 10 cycles ----
      applyReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      pulseVsync();
      @(negedge clk);
      badCount = 0;
      for (int i = 0; i < 10; i++) begin
         if (!(cmdValid === 1'b1 && cmdAddr === 30'd0 && cmdWrite === 1'b0)) badCount++;
         @(negedge clk);
      end
      checkOutput("hold unstable cycles", 32'(badCount), 32'd0);
      cmdReady = 1'b1;
      checkSeq("hold", 0, 16);
      checkFrameEnd("hold");

      // ---- overrun restart at rd_addr = 128 ----
      applyReset();
      applyStimulus(1'b1, 1'b1, 1'b1);
      pulseVsync();
      checkSeq("pre", 0, 3);
      pulseVsync();
      checkOutput("ovr flag set", 32'(overrun), 32'd1);
      checkOutput("ovr no valid", 32'(cmdValid), 32'd0);
      checkOutput("ovr busy", 32'(frameBusy), 32'd1);
      checkSeq("ovr", 0, 16);
      checkFrameEnd("ovr");
      checkOutput("ovr sticky", 32'(overrun), 32'd1);

      // ---- stall statistics: 20 starved ARB cycles ----
      applyReset();
      applyStimulus(1'b0, 1'b0, 1'b1);
      pulseVsync();
      repeat (20) @(negedge clk);
      checkOutput("stall no valid", 32'(cmdValid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkSeq("stall", 0, 16);
      checkOutput("stall count at done", 32'(stallCycles), 32'(ExpStall));
      checkFrameEnd("stall");
      repeat (3) @(negedge clk);
      checkOutput("stall count held", 32'(stallCycles), 32'(ExpStall));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/vram_sched.md
# vram_sched

Frame-sequenced DDR command scheduler in the memory-interface clock domain. Sits between the memory interface's single command port and the two VRAM streams: burst reads that refill the VRAM-to-EPDC FIFO, and burst write-backs that drain the EPDC-to-VRAM FIFO. Each frame trigger starts one linear pass over the waveform-state buffer. Reads are never overtaken by writes and may lead them only by a bounded distance.

## Interface
- `MAX_ADDRESS`, 3840000: frame buffer size in bytes; must be a multiple of the burst byte count.
- `ADDR_W`, 30: byte address width.
- `BURST_WORDS`, 4: 128-bit words per command; burst byte count = BURST_WORDS*16.
- `LEAD_BURSTS`, 4: maximum read lead over writes, in bursts.
- `clk` input 1: memory-interface clock.
- `rst` input 1: asynchronous, active-high reset.
- `vsync` input 1: frame trigger, already synchronized to `clk`; the rising edge starts a frame.
- `ddr_calib_done` input 1: DDR calibration complete.
- `rd_room` input 1: read FIFO can accept one full burst.
- `wr_avail` input 1: write FIFO holds at least one full burst.
- `cmd_valid` output 1: command presented.
- `cmd_ready` input 1: memory interface accepts the command.
- `cmd_write` output 1: 1 = write burst, 0 = read burst.
- `cmd_addr` output ADDR_W: burst start byte address.
- `cmd_bl` output 6: burst length minus one (constant BURST_WORDS-1).
- `frame_busy` output 1: frame pass in progress.
- `frame_done` output 1: one-cycle pulse when both streams reach MAX_ADDRESS.
- `overrun` output 1: sticky flag; a frame trigger arrived while busy.
- `stall_cycles` output 16: see Configuration.

## Operation
- Counters: `rd_addr` and `wr_addr`, ADDR_W bits unsigned. Both clear to 0 at frame start. Each advances by BURST_WORDS*16 on its own command handshake (`cmd_valid && cmd_ready`).
- Read eligible: `rd_room` && `rd_addr < MAX_ADDRESS` && `(rd_addr - wr_addr) < LEAD_BURSTS*BURST_WORDS*16`.
- Write eligible: `wr_avail` && `wr_addr < rd_addr`. `rd_addr >= wr_addr` always holds, so the subtraction never wraps.
- If both streams are eligible, grant the one not granted last (round-robin). The `last` bit resets to "write", so the first contested grant goes to read.
- States:
  - IDLE: wait for a `vsync` edge with `ddr_calib_done` = 1. A `vsync` edge while calibration is 0 is ignored.
  - ARB: evaluate eligibility and go to ISSUE with the chosen type and address. Stay in ARB if nothing is eligible.
  - ISSUE: hold `cmd_valid`. On handshake, update the counter and `last`, then go back to ARB. If both counters equal MAX_ADDRESS after the update, go to DONE instead.
  - DONE: pulse `frame_done`, then go to IDLE.
- A `vsync` edge in ARB or ISSUE sets `overrun`, clears both counters and restarts in ARB. An unacknowledged ISSUE command is withdrawn. This is a permitted deviation from the hold rule below, because the FIFOs are reset by the same trigger.
- `overrun` clears only on `rst`.
- `ddr_calib_done` dropping mid-frame forces IDLE on the next cycle, with counters held.
- `frame_busy` = 1 in ARB and ISSUE.

## Timing
- Reset values: `cmd_valid` 0, `cmd_write` 0, `cmd_addr` 0, `cmd_bl` BURST_WORDS-1, `frame_busy` 0, `frame_done` 0, `overrun` 0, `stall_cycles` 0. State resets to IDLE.
- `vsync` is edge-detected with one register. An edge sampled in cycle N puts the FSM in ARB at N+1; if eligible, `cmd_valid` is high at N+2.
- Handshake: once `cmd_valid` is high, `cmd_write`, `cmd_addr` and `cmd_bl` stay stable until `cmd_ready` (overrun restart is the only exception). `cmd_ready` may be high before `cmd_valid`.
- Command rate: at most one command per 2 cycles (ISSUE→ARB→ISSUE).
- `frame_done` is high for exactly the cycle in DONE. This is one cycle after the final handshake.
- All outputs are registered. There is no combinational path from `cmd_ready` to `cmd_valid`.

## Configuration
- `VRAM_SCHED_STATS_EN` defined:
  - `stall_cycles` counts cycles spent in ARB with nothing eligible, saturating at 0xFFFF.
  - The counter clears at frame start.
  - Its value is latched to the output on `frame_done` and holds until the next `frame_done`.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- MAX_ADDRESS=256, `rd_room`=`wr_avail`=1, `cmd_ready`=1, `vsync` edge → commands: R0, W0, R64, W64, R128, W128, R192, W192. `frame_done` pulses once, `frame_busy` falls with it, `overrun`=0.
- `wr_avail`=1, `rd_room`=1 for 4 reads, then 0 → reads at 0, 64, 128, 192 interleaved with writes. Writes stop at `wr_addr` = `rd_addr`; there is never a write at an address ≥ `rd_addr`.
- `wr_avail`=0, `rd_room`=1 → exactly LEAD_BURSTS=4 reads (0–192), then no command. Setting `wr_avail`=1 resumes writes from W0.
- `cmd_ready` held low 10 cycles on the first command → `cmd_valid`, `cmd_addr`=0 and `cmd_write`=0 stable all 10 cycles, and the counter does not advance.
- `vsync` edge mid-frame at `rd_addr`=128 → `overrun`=1. The next command is R0, and `overrun` stays 1 after the following `frame_done`.
- With `VRAM_SCHED_STATS_EN`: hold `rd_room`=`wr_avail`=0 for 20 cycles after start, then release → `stall_cycles`=20 after `frame_done`. Without the macro: 0.
